// File: rtl/dcache_responder.sv
`default_nettype none
// ============================================================================
// Module   : dcache_responder
// Brief    : Direct-mapped, one-word-per-line data cache with a write-through,
//            no-allocate store path and a single outstanding memory request.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_responder #(
    parameter int WORD_SIZE = 32,
    parameter int INDEX_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 c_read_enable,
    input  logic                 c_write_enable,
    input  logic [WORD_SIZE-1:0] c_ptr,
    input  logic [WORD_SIZE-1:0] c_wdata,
    output logic [WORD_SIZE-1:0] c_out,
    output logic                 c_hit,
    output logic                 c_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack
);

    localparam int c_LINES = 2 ** INDEX_W;
    localparam int c_TAG_W = WORD_SIZE - INDEX_W;

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_HIT_RESP = 3'd1;
    localparam logic [2:0] c_MISS     = 3'd2;
    localparam logic [2:0] c_WRITE    = 3'd3;
    localparam logic [2:0] c_DONE     = 3'd4;

    logic [2:0]           r_state;
    logic [WORD_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0] r_wdata;
    logic [c_LINES-1:0]   r_valid;
    logic [c_TAG_W-1:0]   r_tag  [c_LINES];
    logic [WORD_SIZE-1:0] r_data [c_LINES];
    logic                 r_ready;
    logic                 r_hit;
    logic [WORD_SIZE-1:0] r_out;

    logic [INDEX_W-1:0]   w_req_idx;
    logic [c_TAG_W-1:0]   w_req_tag;
    logic [INDEX_W-1:0]   w_lat_idx;
    logic [c_TAG_W-1:0]   w_lat_tag;
    logic                 w_req_hit;
    logic                 w_lat_hit;
    logic                 w_fill;
    logic                 w_store;

    assign w_req_idx = c_ptr[INDEX_W-1:0];
    assign w_req_tag = c_ptr[WORD_SIZE-1:INDEX_W];
    assign w_lat_idx = r_addr[INDEX_W-1:0];
    assign w_lat_tag = r_addr[WORD_SIZE-1:INDEX_W];

    // Valid bit gates the tag compare, so unreset tag contents never produce a hit.
    assign w_req_hit = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign w_lat_hit = r_valid[w_lat_idx] && (r_tag[w_lat_idx] == w_lat_tag);

    assign w_fill  = (r_state == c_MISS)  && mem_ack;
    assign w_store = (r_state == c_WRITE) && mem_ack && w_lat_hit;

    // Tag/data storage carries no reset; a reset cycle only suppresses updates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_fill) begin
                r_tag[w_lat_idx]  <= w_lat_tag;
                r_data[w_lat_idx] <= mem_rdata;
            end else if (w_store) begin
                r_data[w_lat_idx] <= r_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_valid <= '0;
            r_ready <= 1'b0;
            r_hit   <= 1'b0;
            r_out   <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (c_write_enable) begin
                        r_addr  <= c_ptr;
                        r_wdata <= c_wdata;
                        r_state <= c_WRITE;
                    end else if (c_read_enable) begin
                        r_addr  <= c_ptr;
                        r_state <= w_req_hit ? c_HIT_RESP : c_MISS;
                    end
                end
                c_HIT_RESP: begin
                    r_ready <= 1'b1;
                    r_hit   <= 1'b1;
                    r_out   <= r_data[w_lat_idx];
                    r_state <= c_DONE;
                end
                c_MISS: begin
                    if (mem_ack) begin
                        r_valid[w_lat_idx] <= 1'b1;
                        r_ready            <= 1'b1;
                        r_hit              <= 1'b0;
                        r_out              <= mem_rdata;
                        r_state            <= c_DONE;
                    end
                end
                c_WRITE: begin
                    if (mem_ack) begin
                        r_ready <= 1'b1;
                        r_hit   <= w_lat_hit;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    // A held enable belongs to the request just completed.
                    if (!c_read_enable && !c_write_enable) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign c_ready   = r_ready;
    assign c_hit     = r_hit;
    assign c_out     = r_out;
    assign mem_req   = (r_state == c_MISS) || (r_state == c_WRITE);
    assign mem_we    = (r_state == c_WRITE);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dcache_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_responder
// Brief    : Directed and randomized checks of dcache_responder against a
//            residency-plus-memory reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        c_read_enable = 1'b0;
    logic        c_write_enable = 1'b0;
    logic [31:0] c_ptr = '0;
    logic [31:0] c_wdata = '0;
    logic [31:0] c_out;
    logic        c_hit;
    logic        c_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int tests = 0;
    int fails = 0;

    // Reference model: which tag is resident per index, plus backing memory.
    bit          m_valid [16];
    logic [27:0] m_tag   [16];
    logic [31:0] m_mem   [logic [31:0]];

    always #5 clk = ~clk;

    dcache_responder #(.WORD_SIZE(32), .INDEX_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .c_read_enable  (c_read_enable),
        .c_write_enable (c_write_enable),
        .c_ptr          (c_ptr),
        .c_wdata        (c_wdata),
        .c_out          (c_out),
        .c_hit          (c_hit),
        .c_ready        (c_ready),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; c_read_enable = 1'b0; c_write_enable = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // One complete request: issue, act as memory, check response and hold behaviour.
    task automatic do_req(input bit re, input bit we, input logic [31:0] addr,
                          input logic [31:0] data, input int delay, input int hold);
        int          idx;
        logic [27:0] tag;
        bit          exp_hit;
        logic [31:0] exp_out;
        int          cyc;
        int          nreq;
        bit          done;
        idx     = int'(addr[3:0]);
        tag     = addr[31:4];
        exp_hit = m_valid[idx] && (m_tag[idx] == tag);
        exp_out = '0;
        if (!we) begin
            if (!m_mem.exists(addr)) m_mem[addr] = $urandom;
            exp_out = m_mem[addr];
        end
        @(posedge clk); #1;
        c_read_enable = re; c_write_enable = we; c_ptr = addr; c_wdata = data;
        cyc = 0; nreq = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            mem_ack = 1'b0;
            if (c_ready) begin
                done = 1'b1;
            end else if (mem_req) begin
                nreq++;
                check("mem_we", 32'(mem_we), 32'(we));
                check("mem_addr", mem_addr, addr);
                if (we) check("mem_wdata", mem_wdata, data);
                if (nreq == delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = we ? $urandom : exp_out;
                end
            end
        end
        check("ready_seen", 32'(done), 32'd1);
        if (done) begin
            check("c_hit", 32'(c_hit), 32'(exp_hit));
            if (!we) check("c_out", c_out, exp_out);
            if (!we && exp_hit) begin
                check("hit_latency", 32'(cyc), 32'd2);
                check("hit_no_mem", 32'(nreq), 32'd0);
            end else begin
                check("mem_latency", 32'(cyc), 32'(delay + 1));
                check("mem_req_len", 32'(nreq), 32'(delay));
            end
        end
        // Enables held past completion, with stray mem_acks that must be ignored.
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            check("hold_no_ready", 32'(c_ready), 32'd0);
            check("hold_no_req", 32'(mem_req), 32'd0);
            if (!we) check("hold_c_out", c_out, exp_out);
            mem_ack   = $urandom_range(0, 1) == 1;
            mem_rdata = $urandom;
        end
        c_read_enable = 1'b0; c_write_enable = 1'b0; mem_ack = 1'b0;
        if (we) m_mem[addr] = data;
        else if (!exp_hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
        end
    endtask

    initial begin
        logic [31:0] a;
        do_reset();
        #1;
        check("rst_c_ready", 32'(c_ready), 32'd0);
        check("rst_c_hit", 32'(c_hit), 32'd0);
        check("rst_c_out", c_out, 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);

        // Cold read, warm read, index conflict.
        m_mem[32'h14] = 32'hDEADBEEF;
        do_req(1'b1, 1'b0, 32'h14, 32'h0, 4, 0);
        do_req(1'b1, 1'b0, 32'h14, 32'h0, 1, 1);
        do_req(1'b1, 1'b0, 32'h24, 32'h0, 2, 0);
        do_req(1'b1, 1'b0, 32'h14, 32'h0, 3, 0);

        // Stores: resident line updated, non-resident line not allocated.
        do_req(1'b0, 1'b1, 32'h14, 32'h12345678, 2, 0);
        do_req(1'b1, 1'b0, 32'h14, 32'h0, 1, 0);
        check("store_visible", c_out, 32'h12345678);
        do_req(1'b0, 1'b1, 32'h38, 32'hA5A5_0038, 1, 0);
        do_req(1'b1, 1'b0, 32'h38, 32'h0, 2, 0);

        // Both enables: write wins; held enables never restart.
        do_req(1'b1, 1'b1, 32'h14, 32'hCAFEF00D, 2, 3);
        do_req(1'b1, 1'b0, 32'h14, 32'h0, 1, 2);

        // Reset during a miss aborts it; the late mem_ack is ignored.
        @(posedge clk); #1;
        c_read_enable = 1'b1; c_ptr = 32'h50;
        @(posedge clk); #1;
        check("midmiss_req", 32'(mem_req), 32'd1);
        reset = 1'b1; c_read_enable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            check("abort_no_ready", 32'(c_ready), 32'd0);
            check("abort_no_req", 32'(mem_req), 32'd0);
        end
        do_req(1'b1, 1'b0, 32'h50, 32'h0, 2, 0);
        do_req(1'b1, 1'b0, 32'h14, 32'h0, 1, 0);

        // Randomized traffic over a few tags and indices to force hits and conflicts.
        for (int n = 0; n < 80; n++) begin
            int op;
            a  = {26'($urandom_range(0, 2)), 6'd0} | 32'($urandom_range(0, 7));
            a  = {a[31:6], 2'b00, a[3:0]} | (32'($urandom_range(0, 2)) << 4);
            op = $urandom_range(0, 9);
            if (op < 3)
                do_req(1'b0, 1'b1, a, $urandom, $urandom_range(1, 4), $urandom_range(0, 2));
            else if (op == 3)
                do_req(1'b1, 1'b1, a, $urandom, $urandom_range(1, 4), $urandom_range(0, 2));
            else
                do_req(1'b1, 1'b0, a, 32'h0, $urandom_range(1, 4), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
